bram_sdp: RTL and testbench
===========================

# bram_sdp

Parametrised simple-dual-port block RAM with per-byte write enables, a self-clearing sweep after reset, and a registered read port with a valid strobe. It replaces fixed-width 8-bit RAM stubs wherever the core needs word-wide instruction or data storage. It has one write port and one read port on a single clock.

## Interface
- ADDR_W, default 12: address width; depth = 2^ADDR_W words.
- DATA_W, default 32: word width; must be a multiple of BYTE_W.
- BYTE_W, default 8: byte-lane width; NB = DATA_W/BYTE_W lanes.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  NB  byte-lane enables; bit i enables wr_data[i*BYTE_W +: BYTE_W].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle strobe; rd_data is new this cycle.
- init_done  out  1  high once the clear sweep has finished.

## Operation
- State machine with two states, CLEAR and READY. Reset enters CLEAR with the sweep counter at 0.
- CLEAR:
  - each cycle writes all-zero to address = counter, then increments the counter;
  - external wr_en and rd_en are ignored, and ignored requests are dropped, not queued;
  - the cycle that writes address 2^ADDR_W-1 transitions to READY.
- READY:
  - permanent until the next reset; init_done = 1.
  - Write when wr_en=1: lanes with wr_be[i]=1 are updated, other lanes keep their contents; wr_be=0 is a no-op.
  - Read when rd_en=1: the word at rd_addr is captured into rd_data, and rd_valid=1 on the following cycle.
  - When rd_en=0, rd_data holds its last value and rd_valid=0.
- Simultaneous write and read to different addresses: both take effect independently.
- Simultaneous write and read to the same address: behaviour is set by the Configuration section.
- Addresses span the full 2^ADDR_W range; there is no out-of-range case.
- Reset asserted mid-operation: immediate return to CLEAR.
  - Any in-flight read is discarded (rd_valid=0).
  - The sweep restarts at address 0 and rewrites the whole array.

## Timing
- Reset values: rd_data = 0, rd_valid = 0, init_done = 0, state = CLEAR, counter = 0.
- Sweep length: exactly 2^ADDR_W cycles from the first posedge after rst_n deasserts.
  - init_done rises on the edge that completes the last clear write.
  - The first accepted request is in the cycle where init_done=1 is already visible.
- Read latency is 1 cycle: request at edge N yields rd_data/rd_valid after edge N+1.
- Back-to-back reads are sustained one per cycle, and rd_valid stays high continuously.
- Write latency is 1 cycle: a read issued at the edge after the write returns the new data.

## Configuration
- BRAM_WR_FWD_EN defined: same-cycle, same-address read returns the post-write word.
  - Enabled lanes come from wr_data; disabled lanes come from the old contents.
- BRAM_WR_FWD_EN undefined: same-cycle, same-address read returns the pre-write (old) word.
  - This is plain read-first BRAM behaviour, with no forwarding mux.

## Test plan
- Sweep, ADDR_W=4: preload the array with 0xFFFFFFFF via backdoor, reset, then count cycles.
  - init_done must rise after exactly 16 cycles.
  - Reads of all 16 addresses must return 0x00000000.
  - A write and a read issued during the sweep must have no effect and produce no rd_valid.
- Byte enables: write 0xAABBCCDD with be=1111 to address 5, then write 0x11223344 with be=0101.
  - A read of address 5 must return 0xAA22CC44.
  - A write with be=0000 must leave the word unchanged.
- Read-during-write: address 3 holds 0x00000000; in the same cycle write 0xDEADBEEF with be=0011 and read address 3.
  - With BRAM_WR_FWD_EN: rd_data = 0x0000BEEF.
  - Without BRAM_WR_FWD_EN: rd_data = 0x00000000.
  - In both cases, a read on the next cycle returns 0x0000BEEF.
- Streaming reads: rd_en held high for 8 cycles over addresses 0..7 holding the values k*0x01010101.
  - rd_valid must stay high for exactly 8 consecutive cycles, starting one cycle after the first request.
  - Data must arrive in order.
  - When rd_en drops, rd_data must hold its last value.
- Mid-operation reset: assert rst_n=0 for 1 cycle while a read is in flight and address 9 holds 0x12345678.
  - rd_valid, rd_data and init_done must go to 0 immediately.
  - After the sweep, address 9 must read 0x00000000.

Source files
------------

// File: rtl/bram_sdp.sv
// Simple-dual-port RAM with per-byte write enables and a zero-fill sweep after reset; optional BRAM_WR_FWD_EN forwards same-address writes to the read port.
// Latency: writes land 1 cycle after the request; reads return rd_data/rd_valid 1 cycle after the request; the sweep takes 2^ADDR_W cycles.
// Backpressure: none; requests arriving while init_done=0 are dropped, and afterwards one write plus one read are accepted every cycle.
module bram_sdp #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int BYTE_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/BYTE_W-1:0]   wr_be,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       init_done
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]   cnt_d;
    logic                wr_fire;
    logic                rd_fire;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;

    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    // State and sweep-counter registers; reset restarts the sweep from address 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep one address per cycle, leave CLEAR on the last address
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_fire = 1'b0;
        rd_fire = 1'b0;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = READY;
                end
            end
            READY: begin
                wr_fire = wr_en;
                rd_fire = rd_en;
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Array write port: zero-fill while clearing, otherwise byte-lane masked writes
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[cnt_q] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

`ifdef BRAM_WR_FWD_EN
    // Read word: on a same-address collision, enabled lanes take the incoming write data
    always_comb begin
        rd_word = mem[rd_addr];
        if (wr_fire && (wr_addr == rd_addr)) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    rd_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end
`else
    // Read word: read-first, so a same-address collision returns the old contents
    always_comb begin
        rd_word = mem[rd_addr];
    end
`endif

    // Registered read port; data holds between reads, valid is a one-cycle strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= rd_word;
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign init_done = (state_q == READY);

endmodule

// File: tb/tb_bram_sdp.sv
// Testbench for bram_sdp at ADDR_W=4; expectations track the BRAM_WR_FWD_EN build setting.
// Latency: inputs are driven 1 time unit after a posedge and outputs are sampled at the same point.
// Backpressure: not applicable; every wait on the DUT is bounded by a cycle budget.
module tb_bram_sdp;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int BYTE_W = 8;
    localparam int NB     = DATA_W / BYTE_W;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NB-1:0]     wr_be;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              init_done;

    int checks   = 0;
    int failures = 0;

    // Reference contents of the array, maintained from the write rules
    logic [DATA_W-1:0] model [DEPTH];

    bram_sdp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BYTE_W(BYTE_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result of writing new_w over old_w with byte enables be
    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [NB-1:0] be);
        logic [DATA_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) mask = mask | ({{(DATA_W-BYTE_W){1'b0}}, {BYTE_W{1'b1}}} << (i*BYTE_W));
        end
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [NB-1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        step();
        wr_en = 1'b0; wr_be = '0;
        model[a] = merge(model[a], d, be);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d,
                           output logic v);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0;
        d = rd_data;
        v = rd_valid;
    endtask

    // Steps until init_done is seen, returning the number of edges taken (bounded)
    task automatic wait_sweep(output int cycles, output logic saw_valid);
        cycles = 0;
        saw_valid = 1'b0;
        while (!init_done && cycles < 4*DEPTH) begin
            step();
            cycles++;
            if (rd_valid) saw_valid = 1'b1;
        end
    endtask

    task automatic test_reset();
        int cycles;
        logic sv;
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (rd_data !== '0 || rd_valid !== 1'b0 || init_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: rd_data=%h rd_valid=%b init_done=%b, required 0/0/0",
                     rd_data, rd_valid, init_done);
        end
        rst_n = 1'b1;
        wait_sweep(cycles, sv);
        clear_model();
        checks++;
        if (cycles != DEPTH) begin
            failures++;
            $display("FAIL first_sweep_len: got %0d cycles, required %0d", cycles, DEPTH);
        end
    endtask

    task automatic test_sweep();
        int cycles;
        logic saw_valid;
        logic [DATA_W-1:0] d;
        logic v;
        for (int i = 0; i < DEPTH; i++) do_write(ADDR_W'(i), 32'hFFFF_FFFF, '1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        clear_model();
        cycles = 0;
        saw_valid = 1'b0;
        while (!init_done && cycles < 4*DEPTH) begin
            if (cycles == 5) begin
                wr_en = 1'b1; wr_addr = '0; wr_data = 32'h5555_5555; wr_be = '1;
                rd_en = 1'b1; rd_addr = '0;
            end else begin
                idle_inputs();
            end
            step();
            cycles++;
            if (rd_valid) saw_valid = 1'b1;
        end
        idle_inputs();
        checks++;
        if (cycles != DEPTH) begin
            failures++;
            $display("FAIL sweep_len: got %0d cycles, required %0d", cycles, DEPTH);
        end
        checks++;
        if (saw_valid !== 1'b0) begin
            failures++;
            $display("FAIL sweep_rd_valid: rd_valid seen during sweep=%b, required 0", saw_valid);
        end
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL sweep_end_valid: rd_valid=%b, required 0", rd_valid);
        end
        for (int i = 0; i < DEPTH; i++) begin
            do_read(ADDR_W'(i), d, v);
            checks++;
            if (v !== 1'b1 || d !== 32'h0) begin
                failures++;
                $display("FAIL sweep_zero[%0d]: data=%h valid=%b, required 00000000/1", i, d, v);
            end
        end
    endtask

    task automatic test_byte_en();
        logic [DATA_W-1:0] d;
        logic v;
        do_write(4'd5, 32'hAABB_CCDD, 4'b1111);
        do_write(4'd5, 32'h1122_3344, 4'b0101);
        do_read(4'd5, d, v);
        checks++;
        if (d !== 32'hAA22_CC44 || v !== 1'b1) begin
            failures++;
            $display("FAIL byte_en_merge: data=%h valid=%b, required aa22cc44/1", d, v);
        end
        do_write(4'd5, 32'h9999_9999, 4'b0000);
        do_read(4'd5, d, v);
        checks++;
        if (d !== 32'hAA22_CC44) begin
            failures++;
            $display("FAIL byte_en_none: data=%h, required aa22cc44", d);
        end
        for (int n = 0; n < 20; n++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'($urandom_range(0, DEPTH-1));
            do_write(a, $urandom, NB'($urandom));
            do_read(a, d, v);
            checks++;
            if (d !== model[a]) begin
                failures++;
                $display("FAIL byte_en_rand addr=%0d: data=%h, required %h", a, d, model[a]);
            end
        end
    endtask

    task automatic test_rdw();
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp;
        logic v;
        do_write(4'd3, 32'h0, 4'b1111);
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEAD_BEEF; wr_be = 4'b0011;
        rd_en = 1'b1; rd_addr = 4'd3;
        step();
        idle_inputs();
        model[3] = merge(model[3], 32'hDEAD_BEEF, 4'b0011);
`ifdef BRAM_WR_FWD_EN
        exp = 32'h0000_BEEF;
`else
        exp = 32'h0000_0000;
`endif
        checks++;
        if (rd_data !== exp || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL rdw_same_cycle: data=%h valid=%b, required %h/1", rd_data, rd_valid, exp);
        end
        do_read(4'd3, d, v);
        checks++;
        if (d !== 32'h0000_BEEF) begin
            failures++;
            $display("FAIL rdw_next_cycle: data=%h, required 0000beef", d);
        end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 8; k++) do_write(ADDR_W'(k), 32'h0101_0101 * k, '1);
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_pre_valid: rd_valid=%b, required 0", rd_valid);
        end
        for (int k = 0; k < 8; k++) begin
            rd_en = 1'b1; rd_addr = ADDR_W'(k);
            step();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 32'h0101_0101 * k) begin
                failures++;
                $display("FAIL stream[%0d]: data=%h valid=%b, required %h/1",
                         k, rd_data, rd_valid, 32'h0101_0101 * k);
            end
        end
        rd_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (rd_valid !== 1'b0 || rd_data !== 32'h0707_0707) begin
                failures++;
                $display("FAIL stream_hold[%0d]: data=%h valid=%b, required 07070707/0",
                         k, rd_data, rd_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp;
        logic [DATA_W-1:0] last;
        logic              exp_v;
        last = rd_data;
        for (int n = 0; n < 300; n++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = ADDR_W'($urandom_range(0, DEPTH-1));
            wr_data = $urandom;
            wr_be   = NB'($urandom);
            rd_en   = ($urandom_range(0, 3) != 0);
            rd_addr = (($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom_range(0, DEPTH-1)));
            exp_v = rd_en;
            exp   = last;
            if (rd_en) begin
                exp = model[rd_addr];
`ifdef BRAM_WR_FWD_EN
                if (wr_en && wr_addr == rd_addr) exp = merge(model[rd_addr], wr_data, wr_be);
`endif
            end
            if (wr_en) model[wr_addr] = merge(model[wr_addr], wr_data, wr_be);
            step();
            checks++;
            if (rd_valid !== exp_v || rd_data !== exp) begin
                failures++;
                $display("FAIL b2b[%0d]: data=%h valid=%b, required %h/%b",
                         n, rd_data, rd_valid, exp, exp_v);
            end
            last = exp;
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        int cycles;
        logic sv;
        logic [DATA_W-1:0] d;
        logic v;
        do_write(4'd9, 32'h1234_5678, '1);
        rd_en = 1'b1; rd_addr = 4'd9;
        step();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL midrst_pre: data=%h valid=%b, required 12345678/1", rd_data, rd_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== '0 || init_done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async: data=%h valid=%b init_done=%b, required 0/0/0",
                     rd_data, rd_valid, init_done);
        end
        idle_inputs();
        step();
        rst_n = 1'b1;
        clear_model();
        wait_sweep(cycles, sv);
        checks++;
        if (cycles != DEPTH || sv !== 1'b0) begin
            failures++;
            $display("FAIL midrst_sweep: cycles=%0d valid_seen=%b, required %0d/0", cycles, sv, DEPTH);
        end
        do_read(4'd9, d, v);
        checks++;
        if (d !== 32'h0 || v !== 1'b1) begin
            failures++;
            $display("FAIL midrst_addr9: data=%h valid=%b, required 00000000/1", d, v);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        clear_model();
        test_reset();
        test_sweep();
        test_byte_en();
        test_rdw();
        test_stream();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
